// File: rtl/pipe_ctrl.sv
// Pipeline control unit: per-stage shadow state, freeze / flush / load-use / advance steering.
// Optional build macro PIPE_CTRL_BRANCH_STALL_EN: stall fetch behind B/J instead of speculating not-taken.
module pipe_ctrl #(
  parameter int unsigned STAGES    = 5,
  parameter int unsigned BR_STAGE  = 2,
  parameter int unsigned MEM_STAGE = 3,
  parameter int unsigned LOAD_LAT  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [6:0]        if_opcode,
  input  logic [2:0]        if_funct3,
  input  logic [4:0]        if_rd,
  input  logic [4:0]        if_rs1,
  input  logic [4:0]        if_rs2,
  input  logic              br_resolve,
  input  logic              br_taken,
  input  logic              mem_ready,
  output logic              stall_fetch,
  output logic [1:0]        fetch_sel,
  output logic [STAGES-1:0] stage_valid,
  output logic              store_mem,
  output logic              load_mem,
  output logic              store_reg,
  output logic [2:0]        size
);

  localparam logic [1:0] FETCH_SEL_PC     = 2'd0;
  localparam logic [1:0] FETCH_SEL_NOP    = 2'd1;
  localparam logic [1:0] FETCH_SEL_BRANCH = 2'd2;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam int unsigned EX_STAGE = 2;

  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd;
  } stage_t;

  function automatic logic is_load(input logic [6:0] op);
    return op == OP_LOAD;
  endfunction

  function automatic logic is_store(input logic [6:0] op);
    return op == OP_STORE;
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL);
  endfunction

  stage_t     st_q  [STAGES];
  stage_t     st_d  [STAGES];
  logic [4:0] rs1_q [2];
  logic [4:0] rs2_q [2];
  logic [4:0] rs1_d [2];
  logic [4:0] rs2_d [2];

  logic freeze, flush, load_use, hazard, br_stall, unused_fields;

  // Action decode, highest priority first: freeze, flush, load-use
  always_comb begin
    freeze = st_q[MEM_STAGE].valid && !mem_ready &&
             (is_load(st_q[MEM_STAGE].opcode) || is_store(st_q[MEM_STAGE].opcode));
    hazard = 1'b0;
    for (int unsigned s = 2; s < STAGES; s++) begin
      if (s <= 1 + LOAD_LAT && st_q[s].valid && is_load(st_q[s].opcode) &&
          st_q[s].rd != 5'd0 && (st_q[s].rd == rs1_q[1] || st_q[s].rd == rs2_q[1]))
        hazard = 1'b1;
    end
    flush    = !freeze && br_resolve && br_taken;
    load_use = !freeze && !flush && st_q[1].valid && hazard;
  end

`ifdef PIPE_CTRL_BRANCH_STALL_EN
  // Any unresolved B/J in front of the resolve stage keeps fetch closed
  always_comb begin
    br_stall = 1'b0;
    for (int unsigned s = 0; s < BR_STAGE; s++) begin
      if (st_q[s].valid && is_ctrl(st_q[s].opcode))
        br_stall = 1'b1;
    end
  end
`else
  assign br_stall = 1'b0;
`endif

  // Fetch steering
  always_comb begin
    stall_fetch = 1'b0;
    fetch_sel   = FETCH_SEL_PC;
    if (freeze) begin
      stall_fetch = 1'b1;
      fetch_sel   = FETCH_SEL_NOP;
    end else if (flush) begin
      fetch_sel   = FETCH_SEL_BRANCH;
    end else if (load_use || br_stall) begin
      stall_fetch = 1'b1;
      fetch_sel   = FETCH_SEL_NOP;
    end
  end

  // Stage next-state
  always_comb begin
    st_d  = st_q;
    rs1_d = rs1_q;
    rs2_d = rs2_q;
    if (!freeze) begin
      if (load_use) begin
        for (int unsigned i = EX_STAGE + 1; i < STAGES; i++)
          st_d[i] = st_q[i-1];
        st_d[EX_STAGE] = '0;
      end else begin
        for (int unsigned i = 1; i < STAGES; i++)
          st_d[i] = st_q[i-1];
        st_d[0]  = '{valid: if_valid && !br_stall, opcode: if_opcode, funct3: if_funct3, rd: if_rd};
        rs1_d[0] = if_rs1;
        rs2_d[0] = if_rs2;
        rs1_d[1] = rs1_q[0];
        rs2_d[1] = rs2_q[0];
        if (flush) begin
          for (int unsigned i = 0; i <= BR_STAGE; i++)
            st_d[i].valid = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < STAGES; i++)
        st_q[i] <= '0;
      for (int unsigned j = 0; j < 2; j++) begin
        rs1_q[j] <= '0;
        rs2_q[j] <= '0;
      end
    end else begin
      st_q  <= st_d;
      rs1_q <= rs1_d;
      rs2_q <= rs2_d;
    end
  end

  // EX-stage controls and valid vector
  always_comb begin
    stage_valid = '0;
    for (int unsigned i = 0; i < STAGES; i++)
      stage_valid[i] = st_q[i].valid;
    load_mem  = st_q[EX_STAGE].valid && is_load(st_q[EX_STAGE].opcode);
    store_mem = st_q[EX_STAGE].valid && is_store(st_q[EX_STAGE].opcode);
    store_reg = st_q[EX_STAGE].valid && !is_store(st_q[EX_STAGE].opcode) &&
                (st_q[EX_STAGE].opcode != OP_BRANCH);
    size = 3'd0;
    if (load_mem || store_mem) begin
      case (st_q[EX_STAGE].funct3[1:0])
        2'b00:   size = 3'd1;
        2'b01:   size = 3'd2;
        2'b10:   size = 3'd4;
        default: size = 3'd0;
      endcase
    end
  end

  // Shadow fields not consumed by every stage
  always_comb begin
    unused_fields = 1'b0;
    for (int unsigned i = 0; i < STAGES; i++)
      unused_fields = unused_fields ^ (^st_q[i]);
    unused_fields = unused_fields ^ is_ctrl(if_opcode);
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: fill, flush, load-use, freeze, size decode, reset mid-freeze.
module tb_pipe_ctrl;

  localparam logic [1:0] SEL_PC     = 2'd0;
  localparam logic [1:0] SEL_NOP    = 2'd1;
  localparam logic [1:0] SEL_BRANCH = 2'd2;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ADD   = 7'b0110011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       if_valid;
  logic [6:0] if_opcode;
  logic [2:0] if_funct3;
  logic [4:0] if_rd, if_rs1, if_rs2;
  logic       br_resolve, br_taken, mem_ready;
  logic       stall_fetch;
  logic [1:0] fetch_sel;
  logic [4:0] stage_valid;
  logic       store_mem, load_mem, store_reg;
  logic [2:0] size;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.STAGES(5), .BR_STAGE(2), .MEM_STAGE(3), .LOAD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_opcode(if_opcode), .if_funct3(if_funct3),
    .if_rd(if_rd), .if_rs1(if_rs1), .if_rs2(if_rs2),
    .br_resolve(br_resolve), .br_taken(br_taken), .mem_ready(mem_ready),
    .stall_fetch(stall_fetch), .fetch_sel(fetch_sel), .stage_valid(stage_valid),
    .store_mem(store_mem), .load_mem(load_mem), .store_reg(store_reg), .size(size)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    if_valid = v; if_opcode = op; if_funct3 = f3;
    if_rd = rd; if_rs1 = rs1; if_rs2 = rs2;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    fetch(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    br_resolve = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stall"}, stall_fetch, 0);
    check({tag, "_sel"},   fetch_sel, SEL_PC);
    check({tag, "_valid"}, stage_valid, 0);
    check({tag, "_smem"},  store_mem, 0);
    check({tag, "_lmem"},  load_mem, 0);
    check({tag, "_sreg"},  store_reg, 0);
    check({tag, "_size"},  size, 0);
  endtask

  // LW in s2 against a dependent op in s1; stall expectation supplied by caller
  task automatic load_use_case(input logic [4:0] ld_rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic exp_stall);
    do_reset;
    fetch(1'b1, OP_LOAD, 3'b010, ld_rd, 5'd2, 5'd0); tick;
    fetch(1'b1, OP_ADD, 3'b000, 5'd6, rs1, rs2);      tick;
    fetch(1'b1, OP_ADDI, 3'b000, 5'd7, 5'd0, 5'd0);   tick;
    check("lu_stall", stall_fetch, 32'(exp_stall));
    check("lu_sel", fetch_sel, exp_stall ? SEL_NOP : SEL_PC);
    check("lu_lmem", load_mem, 1);
    check("lu_size", size, 4);
    tick;
    check("lu_valid", stage_valid, exp_stall ? 5'b01011 : 5'b01111);
    check("lu_ex_sreg", store_reg, exp_stall ? 0 : 1);
    if (exp_stall) begin
      tick;
      check("lu_after_sreg", store_reg, 1);
      check("lu_after_stall", stall_fetch, 0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    fetch(1'b0, 7'd0, 3'd0, 5'd0, 5'd0, 5'd0);
    br_resolve = 1'b0; br_taken = 1'b0; mem_ready = 1'b1;
    #3;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // ADDI stream fills the pipe
    fetch(1'b1, OP_ADDI, 3'b000, 5'd1, 5'd0, 5'd0);
    for (int k = 1; k <= 5; k++) begin
      tick;
      check("fill_valid", stage_valid, 32'((1 << k) - 1));
      check("fill_sel", fetch_sel, SEL_PC);
      check("fill_sreg", store_reg, k >= 3 ? 1 : 0);
    end

`ifndef PIPE_CTRL_BRANCH_STALL_EN
    // Taken BEQ resolving in stage 2 squashes stages 0..2
    do_reset;
    fetch(1'b1, OP_BEQ, 3'b000, 5'd0, 5'd1, 5'd2); tick;
    fetch(1'b1, OP_ADDI, 3'b000, 5'd1, 5'd0, 5'd0); tick; tick;
    check("br_pre_valid", stage_valid, 5'b00111);
    check("br_pre_sreg", store_reg, 0);
    br_resolve = 1'b1; br_taken = 1'b1; #1;
    check("br_sel", fetch_sel, SEL_BRANCH);
    check("br_stall", stall_fetch, 0);
    tick;
    br_resolve = 1'b0; br_taken = 1'b0;
    check("br_flush_valid", stage_valid, 5'b01000);
    tick;
    check("br_refill_valid", stage_valid, 5'b10001);
`endif

    load_use_case(5'd5, 5'd5, 5'd1, 1'b1);
    load_use_case(5'd0, 5'd0, 5'd1, 1'b0);
    load_use_case(5'd5, 5'd1, 5'd5, 1'b1);

    // SW waits 3 cycles for memory; mid-freeze branch is ignored
    do_reset;
    fetch(1'b1, OP_STORE, 3'b010, 5'd0, 5'd2, 5'd3); tick;
    fetch(1'b1, OP_ADDI, 3'b000, 5'd1, 5'd0, 5'd0); tick; tick;
    check("sw_smem", store_mem, 1);
    check("sw_size", size, 4);
    check("sw_sreg", store_reg, 0);
    tick;
    mem_ready = 1'b0; #1;
    check("frz_stall", stall_fetch, 1);
    check("frz_sel0", fetch_sel, SEL_NOP);
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin br_resolve = 1'b1; br_taken = 1'b1; #1; end
      check("frz_sel", fetch_sel, SEL_NOP);
      tick;
      br_resolve = 1'b0; br_taken = 1'b0;
      check("frz_valid", stage_valid, 5'b01111);
    end
    mem_ready = 1'b1; #1;
    check("frz_rel_stall", stall_fetch, 0);
    check("frz_rel_sel", fetch_sel, SEL_PC);
    tick;
    check("frz_rel_valid", stage_valid, 5'b11111);

    // Access size decode, valid and invalid in stage 2
    do_reset;
    fetch(1'b1, OP_LOAD, 3'b001, 5'd3, 5'd1, 5'd0);  tick;
    fetch(1'b1, OP_STORE, 3'b000, 5'd0, 5'd0, 5'd4); tick;
    fetch(1'b0, OP_LOAD, 3'b001, 5'd3, 5'd0, 5'd0);  tick;
    check("lh_lmem", load_mem, 1);
    check("lh_smem", store_mem, 0);
    check("lh_size", size, 2);
    fetch(1'b0, OP_STORE, 3'b000, 5'd0, 5'd0, 5'd0); tick;
    check("sb_smem", store_mem, 1);
    check("sb_lmem", load_mem, 0);
    check("sb_size", size, 1);
    tick;
    check("lh_inv_lmem", load_mem, 0);
    check("lh_inv_size", size, 0);
    tick;
    check("sb_inv_smem", store_mem, 0);
    check("sb_inv_size", size, 0);

`ifdef PIPE_CTRL_BRANCH_STALL_EN
    // JAL closes fetch for two slots, then resolves taken without squashing
    do_reset;
    fetch(1'b1, OP_JAL, 3'b000, 5'd1, 5'd0, 5'd0); tick;
    fetch(1'b1, OP_ADDI, 3'b000, 5'd2, 5'd0, 5'd0); #1;
    check("bs_stall0", stall_fetch, 1);
    check("bs_sel0", fetch_sel, SEL_NOP);
    tick;
    check("bs_valid1", stage_valid, 5'b00010);
    check("bs_stall1", stall_fetch, 1);
    tick;
    check("bs_valid2", stage_valid, 5'b00100);
    check("bs_sreg", store_reg, 1);
    br_resolve = 1'b1; br_taken = 1'b1; #1;
    check("bs_sel_br", fetch_sel, SEL_BRANCH);
    tick;
    br_resolve = 1'b0; br_taken = 1'b0;
    check("bs_valid3", stage_valid, 5'b01000);
    #2;
    rst_n = 1'b0; #1;
    check_idle("bs_rst");
`endif

    // Asynchronous reset in the middle of a freeze
    do_reset;
    fetch(1'b1, OP_STORE, 3'b010, 5'd0, 5'd2, 5'd3); tick;
    fetch(1'b1, OP_ADDI, 3'b000, 5'd1, 5'd0, 5'd0); tick; tick; tick;
    mem_ready = 1'b0; #1;
    check("rf_stall", stall_fetch, 1);
    rst_n = 1'b0; #1;
    check("rf_rst_stall", stall_fetch, 0);
    check("rf_rst_sel", fetch_sel, SEL_PC);
    check("rf_rst_valid", stage_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    check("rf_post_valid", stage_valid, 5'b00001);
    check("rf_post_stall", stall_fetch, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
